// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: CSR file (mstatus/mtvec/mepc/mcause/mtval) plus trap/mret sequencing FSM.
// Latency: trap entry 3 cycles (IDLE->FLUSH->SAVE->REDIRECT), mret 1 cycle; CSR read data is combinational.
// Backpressure: REDIRECT holds redirect_valid_o/redirect_pc_o until redirect_ready_i; busy_o stalls the pipeline meanwhile.
module trap_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            fe_exc_i,
    input  logic            de_exc_i,
    input  logic            ex_exc_i,
    input  logic [3:0]      ex_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,

    input  logic            mret_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,

    output logic [XLEN-1:0] csr_rdata_o,
    output logic            flush_o,
    output logic            busy_o,

    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,

    output logic            mie_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    // mepc is always halfword aligned, mtvec only supports direct mode
    localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_SAVE     = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            flush_q, flush_d;
    logic            busy_q, busy_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    // trap information captured on the IDLE->FLUSH transition
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;

    // architectural CSR state
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;

    logic trap_any;
    logic in_idle;
    logic in_save;
    logic take_mret;
    logic sw_mstatus;
    logic sw_mtvec;
    logic sw_mepc;
    logic sw_mcause;
    logic sw_mtval;

    assign trap_any  = fe_exc_i | de_exc_i | ex_exc_i;
    assign in_idle   = (state_q == S_IDLE);
    assign in_save   = (state_q == S_SAVE);
    // an exception in the same cycle wins and the mret is simply lost
    assign take_mret = in_idle & mret_i & ~trap_any;

    assign sw_mstatus = csr_we_i & (csr_addr_i == ADDR_MSTATUS);
    assign sw_mtvec   = csr_we_i & (csr_addr_i == ADDR_MTVEC);
    assign sw_mepc    = csr_we_i & (csr_addr_i == ADDR_MEPC);
    assign sw_mcause  = csr_we_i & (csr_addr_i == ADDR_MCAUSE);
    assign sw_mtval   = csr_we_i & (csr_addr_i == ADDR_MTVAL);

    // next-state, trap capture and registered-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        rpc_d   = rpc_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;

        unique case (state_q)
            S_IDLE: begin
                if (trap_any) begin
                    state_d = S_FLUSH;
                    epc_d   = exc_pc_i;
                    tval_d  = exc_tval_i;
                    if (ex_exc_i) begin
                        cause_d = ex_cause_i;
                    end else if (de_exc_i) begin
                        cause_d = 4'd2;
                    end else begin
                        cause_d = 4'd1;
                    end
                end else if (mret_i) begin
                    state_d = S_REDIRECT;
                    rpc_d   = mepc_q;
                end
            end
            S_FLUSH: begin
                state_d = S_SAVE;
            end
            S_SAVE: begin
                state_d = S_REDIRECT;
                rpc_d   = mtvec_q;
            end
            S_REDIRECT: begin
                // target is frozen while waiting for fetch to accept it
                if (redirect_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        flush_d  = (state_d == S_FLUSH);
        busy_d   = (state_d != S_IDLE);
        rvalid_d = (state_d == S_REDIRECT);
    end

    // CSR updates: the SAVE-cycle trap write beats a colliding software write
    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mtvec_d  = mtvec_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;

        if (in_save) begin
            mepc_d   = epc_q & MEPC_MASK;
            mcause_d = {{(XLEN-4){1'b0}}, cause_q};
            mtval_d  = tval_q;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (sw_mepc) begin
                mepc_d = csr_wdata_i & MEPC_MASK;
            end
            if (sw_mcause) begin
                mcause_d = csr_wdata_i;
            end
            if (sw_mtval) begin
                mtval_d = csr_wdata_i;
            end
            // an explicit software write to mstatus overrides the mret stack pop
            if (sw_mstatus) begin
                mie_d  = csr_wdata_i[3];
                mpie_d = csr_wdata_i[7];
            end else if (take_mret) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end
        end

        // mtvec is never written by the trap sequence, so software always lands
        if (sw_mtvec) begin
            mtvec_d = csr_wdata_i & MTVEC_MASK;
        end
    end

    // combinational CSR read mux; unimplemented addresses read as zero
    always_comb begin
        csr_rdata_o = '0;
        unique case (csr_addr_i)
            ADDR_MSTATUS: begin
                csr_rdata_o[3] = mie_q;
                csr_rdata_o[7] = mpie_q;
            end
            ADDR_MTVEC:  csr_rdata_o = mtvec_q;
            ADDR_MEPC:   csr_rdata_o = mepc_q;
            ADDR_MCAUSE: csr_rdata_o = mcause_q;
            ADDR_MTVAL:  csr_rdata_o = mtval_q;
            default:     csr_rdata_o = '0;
        endcase
    end

    // sequencer state and its registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rpc_q    <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rpc_q    <= rpc_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
        end
    end

    // architectural CSR registers; a reset mid-trap leaves them at reset values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            mtvec_q  <= MTVEC_RST;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mtvec_q  <= mtvec_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    assign flush_o          = flush_q;
    assign busy_o           = busy_q;
    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;
    assign mie_o            = mie_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: randomized traps/mret/CSR writes against an architectural model.
// Expected flush and redirect events are queued at issue time; a negedge monitor pops and compares them.
// Redirect backpressure is exercised with held-low and random redirect_ready_i.
module tb_trap_ctrl;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            fe_exc_i, de_exc_i, ex_exc_i;
    logic [3:0]      ex_cause_i;
    logic [XLEN-1:0] exc_pc_i, exc_tval_i;
    logic            mret_i, csr_we_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            flush_o, busy_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;
    logic            mie_o;

    trap_ctrl #(.XLEN(XLEN), .MTVEC_RST(32'h0000_0100)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .fe_exc_i         (fe_exc_i),
        .de_exc_i         (de_exc_i),
        .ex_exc_i         (ex_exc_i),
        .ex_cause_i       (ex_cause_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .csr_we_i         (csr_we_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_rdata_o      (csr_rdata_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .mie_o            (mie_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- architectural reference model ----------------
    logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec;
    bit          m_mie, m_mpie;

    task automatic model_reset();
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = 32'h100;
        m_mie = 0; m_mpie = 0;
    endtask

    task automatic model_sw(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h305: m_mtvec  = d & 32'hFFFF_FFFC;
            12'h341: m_mepc   = d & 32'hFFFF_FFFE;
            12'h342: m_mcause = d;
            12'h343: m_mtval  = d;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit trap_written(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h341) || (a == 12'h342) || (a == 12'h343);
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int          issue;
        int          lat;
        logic [31:0] pc;
    } red_t;

    red_t red_q[$];
    int   flush_q[$];

    // ---------------- monitor ----------------
    bit          in_red   = 0;
    bit          idle_chk = 0;
    logic [31:0] held_pc;
    int          e_issue;
    red_t        r_cur;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            in_red   = 0;
            idle_chk = 0;
        end else begin
            if (idle_chk) begin
                chk("idle_after_accept", {30'd0, busy_o, redirect_valid_o}, 32'd0);
                idle_chk = 0;
            end
            if (flush_o) begin
                if (flush_q.size() == 0) begin
                    chk("unexpected_flush", 32'd1, 32'd0);
                end else begin
                    e_issue = flush_q.pop_front();
                    chk("flush_cycle", 32'(cyc), 32'(e_issue + 1));
                end
            end
            if (redirect_valid_o) begin
                chk("busy_in_redirect", {31'd0, busy_o}, 32'd1);
                if (!in_red) begin
                    if (red_q.size() == 0) begin
                        chk("unexpected_redirect", 32'd1, 32'd0);
                    end else begin
                        r_cur = red_q.pop_front();
                        chk("redirect_latency", 32'(cyc - r_cur.issue), 32'(r_cur.lat));
                        chk("redirect_pc", redirect_pc_o, r_cur.pc);
                    end
                    held_pc = redirect_pc_o;
                    in_red  = 1;
                end else begin
                    chk("redirect_pc_stable", redirect_pc_o, held_pc);
                end
                if (redirect_ready_i) begin
                    in_red   = 0;
                    idle_chk = 1;
                end
            end else if (in_red) begin
                chk("redirect_valid_held", 32'd0, 32'd1);
                in_red = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        fe_exc_i = 0; de_exc_i = 0; ex_exc_i = 0; ex_cause_i = 0;
        exc_pc_i = 0; exc_tval_i = 0; mret_i = 0;
        csr_we_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
    endtask

    task automatic check_csrs(input string tag);
        logic [11:0] addrs [6];
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};
        csr_we_i = 0;
        for (int i = 0; i < 6; i++) begin
            csr_addr_i = addrs[i];
            #1;
            chk($sformatf("%s_csr_%03h", tag, addrs[i]), csr_rdata_o, model_rd(addrs[i]));
        end
        chk({tag, "_mie_o"}, {31'd0, mie_o}, {31'd0, m_mie});
    endtask

    // run cycles until the controller is idle, driving redirect_ready_i
    task automatic wait_idle(input int hold, input bit rnd);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            clear_inputs();
            if (!busy_o) begin
                done = 1;
                break;
            end
            if (redirect_valid_o) begin
                if (hold > 0) begin
                    redirect_ready_i = 0;
                    hold--;
                end else begin
                    redirect_ready_i = rnd ? 1'($urandom % 2) : 1'b1;
                end
            end else begin
                redirect_ready_i = 0;
            end
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
        chk("queues_drained", 32'(red_q.size() + flush_q.size()), 32'd0);
    endtask

    task automatic do_trap(input bit fe, input bit de, input bit ex, input logic [3:0] cause,
                           input logic [31:0] pc, input logic [31:0] tval,
                           input bit mret_too, input bit spurious,
                           input bit sw_save, input logic [11:0] sw_a, input logic [31:0] sw_d,
                           input int hold, input bit rnd);
        red_t r;
        @(posedge clk_i); #1;
        redirect_ready_i = 0;
        fe_exc_i = fe; de_exc_i = de; ex_exc_i = ex; ex_cause_i = cause;
        exc_pc_i = pc; exc_tval_i = tval; mret_i = mret_too;
        flush_q.push_back(cyc);
        r.issue = cyc; r.lat = 3; r.pc = m_mtvec;
        red_q.push_back(r);
        m_mepc   = pc & 32'hFFFF_FFFE;
        m_mcause = ex ? 32'(cause) : (de ? 32'd2 : 32'd1);
        m_mtval  = tval;
        m_mpie   = m_mie;
        m_mie    = 0;
        // FLUSH cycle: new events here must be ignored
        @(posedge clk_i); #1;
        clear_inputs();
        if (spurious) begin
            fe_exc_i = 1'($urandom % 2); de_exc_i = 1'($urandom % 2);
            ex_exc_i = 1'($urandom % 2); ex_cause_i = 4'($urandom);
            exc_pc_i = $urandom; mret_i = 1'($urandom % 2);
        end
        // SAVE cycle: optional colliding software write
        @(posedge clk_i); #1;
        clear_inputs();
        if (sw_save) begin
            csr_we_i = 1; csr_addr_i = sw_a; csr_wdata_i = sw_d;
            if (!trap_written(sw_a)) model_sw(sw_a, sw_d);
        end
        wait_idle(hold, rnd);
    endtask

    task automatic do_mret(input int hold, input bit rnd);
        red_t r;
        @(posedge clk_i); #1;
        redirect_ready_i = 0;
        mret_i = 1;
        r.issue = cyc; r.lat = 1; r.pc = m_mepc;
        red_q.push_back(r);
        m_mie  = m_mpie;
        m_mpie = 1;
        wait_idle(hold, rnd);
    endtask

    task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        redirect_ready_i = 0;
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        model_sw(a, d);
        @(posedge clk_i); #1;
        clear_inputs();
    endtask

    function automatic logic [11:0] rand_addr();
        logic [11:0] tbl [6];
        tbl = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};
        return tbl[$urandom % 6];
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        red_t r;
        clear_inputs();
        redirect_ready_i = 0;
        rst_ni = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_rvalid", {31'd0, redirect_valid_o}, 32'd0);
        rst_ni = 1;
        check_csrs("reset");

        // decode exception, fetch accepts immediately
        do_trap(0, 1, 0, 4'd0, 32'h200, 32'hDEAD, 0, 0, 0, 12'h0, 32'h0, 0, 0);
        check_csrs("de_trap");

        // ex beats fe in the same cycle
        do_trap(1, 0, 1, 4'd11, 32'h344, 32'h5, 0, 0, 0, 12'h0, 32'h0, 0, 0);
        check_csrs("ex_prio");

        // MIE stacking through a trap and back through mret
        sw_write(12'h300, 32'h0000_0008);
        check_csrs("mie_set");
        do_trap(0, 0, 1, 4'd3, 32'h1000, 32'h77, 0, 0, 0, 12'h0, 32'h0, 0, 0);
        check_csrs("mie_trap");
        do_mret(0, 0);
        check_csrs("mie_mret");

        // fetch stalls the redirect for 5 cycles
        do_trap(1, 0, 0, 4'd0, 32'h2004, 32'h0, 0, 0, 0, 12'h0, 32'h0, 5, 0);
        check_csrs("stall");

        // software mepc write collides with SAVE and loses
        do_trap(0, 1, 0, 4'd0, 32'h3000, 32'hBEEF, 0, 0, 1, 12'h341, 32'h123, 0, 0);
        check_csrs("save_collide");
        sw_write(12'h305, 32'h403);
        check_csrs("mtvec_align");
        do_trap(0, 0, 1, 4'd5, 32'h4001, 32'h9, 0, 0, 0, 12'h0, 32'h0, 0, 0);
        check_csrs("mtvec_target");

        // randomized mix
        for (int it = 0; it < 70; it++) begin
            int op;
            op = $urandom % 4;
            if (op < 2) begin
                logic [2:0] bits;
                bits = 3'($urandom_range(1, 7));
                do_trap(bits[0], bits[1], bits[2], 4'($urandom), $urandom, $urandom,
                        1'($urandom % 4 == 0), 1'($urandom % 2),
                        1'($urandom % 3 == 0), rand_addr(), $urandom,
                        int'($urandom % 3), 1);
            end else if (op == 2) begin
                do_mret(int'($urandom % 3), 1);
            end else begin
                sw_write(rand_addr(), $urandom);
            end
            check_csrs($sformatf("rnd%0d", it));
        end

        // reset asserted while in SAVE
        @(posedge clk_i); #1;
        redirect_ready_i = 1;
        de_exc_i = 1; exc_pc_i = 32'h5550; exc_tval_i = 32'h66;
        flush_q.push_back(cyc);
        r.issue = cyc; r.lat = 3; r.pc = m_mtvec;
        red_q.push_back(r);
        @(posedge clk_i); #1;
        clear_inputs();
        @(posedge clk_i); #1;
        rst_ni = 0;
        #1;
        chk("midrst_flush", {31'd0, flush_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_rvalid", {31'd0, redirect_valid_o}, 32'd0);
        chk("midrst_flush_seen", 32'(flush_q.size()), 32'd0);
        red_q.delete();
        flush_q.delete();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        @(posedge clk_i); #1;
        chk("postrst_busy", {31'd0, busy_o}, 32'd0);
        check_csrs("postrst");
        repeat (3) @(posedge clk_i);
        #1;
        chk("postrst_quiet", {30'd0, busy_o, redirect_valid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
